// File: rtl/best_match_comparator_pkg.sv
// Shared types and sizing for the motion-estimation best-match stage.
package me_pkg;

  localparam int NUM_PE     = 16;
  localparam int DIST_W     = 16;
  localparam int NUM_CAND   = 256;
  localparam int VEC_OFFSET = 7;
  localparam int CNT_W      = 9;
  localparam int IDX_W      = $clog2(NUM_PE);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  typedef logic [DIST_W-1:0] dist_t;
  typedef logic signed [3:0] vec_t;

  // PE index to horizontal vector: bias removed, wrapped to 4 bits.
  function automatic vec_t pe_to_vec(input logic [IDX_W-1:0] idx);
    return vec_t'(4'(idx) - 4'(VEC_OFFSET));
  endfunction

endpackage

// File: rtl/best_match_comparator_if.sv
// Bus between the PE array/control side (master) and the comparator (slave).
interface best_match_comparator_if;
  import me_pkg::*;

  logic                     comp_start;
  logic [NUM_PE-1:0]        pe_ready;
  logic [NUM_PE*DIST_W-1:0] pe_dist;
  vec_t                     vector_y;
  dist_t                    best_dist;
  vec_t                     motion_x;
  vec_t                     motion_y;
  logic [CNT_W-1:0]         cand_count;
  logic                     done;

  modport master (
    output comp_start, pe_ready, pe_dist, vector_y,
    input  best_dist, motion_x, motion_y, cand_count, done
  );

  modport slave (
    input  comp_start, pe_ready, pe_dist, vector_y,
    output best_dist, motion_x, motion_y, cand_count, done
  );

endinterface

// File: rtl/best_match_comparator_picker.sv
// Combinational priority encoder: finds the lowest set bit of a mask and
// returns the mask with that bit removed.
module lowest_set_picker #(
  parameter  int N  = 16,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_mask,
  output logic [IW-1:0] o_index,
  output logic          o_valid,
  output logic [N-1:0]  o_rest
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_mask[i]) o_index = IW'(i);
    end
  end

  assign o_valid = |i_mask;
  // Classic clear-lowest-set-bit trick.
  assign o_rest  = i_mask & (i_mask - N'(1));

endmodule

// File: rtl/best_match_comparator.sv
// Tracks the minimum PE distortion and its motion vector over one search
// window, serialising simultaneous PE results through a pending mask.
module best_match_comparator
  import me_pkg::*;
(
  input logic                      clock,
  input logic                      reset_n,
  best_match_comparator_if.slave   bus
);

  state_t            r_state;
  logic              r_start_prev;
  dist_t             r_best_dist;
  vec_t              r_motion_x;
  vec_t              r_motion_y;
  logic [CNT_W-1:0]  r_cand_count;
  logic              r_done;
  logic [NUM_PE-1:0] r_pending;
  vec_t              r_ypend [NUM_PE];

  dist_t             w_dist [NUM_PE];
  logic [NUM_PE-1:0] w_work;
  logic [NUM_PE-1:0] w_rest;
  logic [IDX_W-1:0]  w_idx;
  logic              w_valid;
  vec_t              w_row;
  dist_t             w_cand_dist;
  logic              w_start_rise;

  // Unpack the flat distortion bus into one word per PE.
  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_dist
    assign w_dist[gi] = bus.pe_dist[gi*DIST_W +: DIST_W];
  end

  assign w_work       = r_pending | bus.pe_ready;
  assign w_start_rise = bus.comp_start & ~r_start_prev;

  lowest_set_picker #(.N(NUM_PE)) u_picker (
    .i_mask  (w_work),
    .o_index (w_idx),
    .o_valid (w_valid),
    .o_rest  (w_rest)
  );

  // A candidate arriving this cycle uses the live row; a deferred one uses
  // the row captured when it first arrived.
  assign w_row       = bus.pe_ready[w_idx] ? bus.vector_y : r_ypend[w_idx];
  assign w_cand_dist = w_dist[w_idx];

  // Capture the row vector for every PE that reports this cycle.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_PE; i++) begin
      if (!reset_n)             r_ypend[i] <= '0;
      else if (bus.pe_ready[i]) r_ypend[i] <= bus.vector_y;
    end
  end

  // Search FSM with the compare/update datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_start_prev <= 1'b0;
      r_best_dist  <= '1;
      r_motion_x   <= '0;
      r_motion_y   <= '0;
      r_cand_count <= '0;
      r_done       <= 1'b0;
      r_pending    <= '0;
    end else begin
      r_start_prev <= bus.comp_start;
      case (r_state)
        IDLE: begin
          if (w_start_rise) begin
            r_state      <= SEARCH;
            r_best_dist  <= '1;
            r_cand_count <= '0;
            r_pending    <= '0;
            r_done       <= 1'b0;
          end
        end
        SEARCH: begin
          if (!bus.comp_start) begin
            // Abort: keep partial results, drop anything still queued.
            r_state   <= IDLE;
            r_pending <= '0;
          end else if (r_cand_count == CNT_W'(NUM_CAND)) begin
            // Window complete; late ready bits are discarded.
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_pending <= '0;
          end else begin
            r_pending <= w_rest;
            if (w_valid) begin
              r_cand_count <= r_cand_count + CNT_W'(1);
              // Strict less-than so ties keep the earlier candidate.
              if (w_cand_dist < r_best_dist) begin
                r_best_dist <= w_cand_dist;
                r_motion_x  <= pe_to_vec(w_idx);
                r_motion_y  <= w_row;
              end
            end
          end
        end
        DONE: begin
          if (!bus.comp_start) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.best_dist  = r_best_dist;
  assign bus.motion_x   = r_motion_x;
  assign bus.motion_y   = r_motion_y;
  assign bus.cand_count = r_cand_count;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_best_match_comparator.sv
// Directed and random stimulus for best_match_comparator, checked against a
// cycle-level reference model of the search rules.
module tb_best_match_comparator;
  import me_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  best_match_comparator_if bus_if ();

  best_match_comparator dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus_if)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] d [16];

  // Reference model state
  int          m_state;   // 0 idle, 1 searching, 2 finished
  logic        m_prev;
  logic [15:0] m_best;
  logic [3:0]  m_mx;
  logic [3:0]  m_my;
  int          m_cnt;
  logic        m_done;
  bit          m_pend [16];
  logic [3:0]  m_row  [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rn, input logic cs, input logic [15:0] rdy,
                            input logic [3:0] vy);
    int k;
    if (!rn) begin
      m_state = 0; m_prev = 1'b0; m_best = 16'hFFFF; m_mx = 4'h0; m_my = 4'h0;
      m_cnt = 0; m_done = 1'b0;
      for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
      return;
    end
    case (m_state)
      0: if (cs && !m_prev) begin
           m_state = 1; m_best = 16'hFFFF; m_cnt = 0; m_done = 1'b0;
           for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
         end
      1: if (!cs) begin
           m_state = 0;
           for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
         end else if (m_cnt == 256) begin
           m_state = 2; m_done = 1'b1;
           for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
         end else begin
           for (int i = 0; i < 16; i++)
             if (rdy[i]) begin m_pend[i] = 1'b1; m_row[i] = vy; end
           k = -1;
           for (int i = 0; i < 16; i++) if (m_pend[i] && k < 0) k = i;
           if (k >= 0) begin
             m_pend[k] = 1'b0;
             m_cnt++;
             if (d[k] < m_best) begin
               m_best = d[k];
               m_mx   = 4'((k - 7) & 15);
               m_my   = m_row[k];
             end
           end
         end
      default: if (!cs) begin m_state = 0; m_done = 1'b0; end
    endcase
    m_prev = cs;
  endtask

  // Apply one cycle of inputs, advance the model at the edge, then compare.
  task automatic step(input logic rn, input logic cs, input logic [15:0] rdy,
                      input logic [3:0] vy);
    rst_n = rn;
    bus_if.comp_start = cs;
    bus_if.pe_ready   = rdy;
    bus_if.vector_y   = vy;
    for (int i = 0; i < 16; i++) bus_if.pe_dist[i*16 +: 16] = d[i];
    @(posedge clk);
    model_edge(rn, cs, rdy, vy);
    #1;
    chk("best_dist",  {16'd0, bus_if.best_dist}, {16'd0, m_best});
    chk("motion_x",   {28'd0, bus_if.motion_x},  {28'd0, m_mx});
    chk("motion_y",   {28'd0, bus_if.motion_y},  {28'd0, m_my});
    chk("cand_count", {23'd0, bus_if.cand_count}, 32'(m_cnt));
    chk("done",       {31'd0, bus_if.done},      {31'd0, m_done});
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 16; i++) d[i] = v;
  endtask

  // One-hot walk over all PEs, row by row; mode 0 plants a single minimum,
  // mode 1 plants two equal minima.
  task automatic sweep(input int mode);
    for (int r = 0; r < 16; r++)
      for (int i = 0; i < 16; i++) begin
        set_all(16'h0100);
        if (mode == 0 && i == 9 && r == 10) d[i] = 16'h0010;
        if (mode == 1 && ((i == 2 && r == 0) || (i == 5 && r == 7))) d[i] = 16'h0005;
        step(1'b1, 1'b1, 16'(1 << i), 4'(r - 7));
      end
  endtask

  task automatic rand_step(input logic cs);
    for (int i = 0; i < 16; i++) d[i] = 16'($urandom_range(0, 65535));
    step(1'b1, cs, 16'($urandom_range(0, 65535) & $urandom_range(0, 65535)),
         4'($urandom_range(0, 15)));
  endtask

  initial begin
    int guard;
    set_all(16'h0000);
    bus_if.comp_start = 1'b0;
    bus_if.pe_ready   = '0;
    bus_if.pe_dist    = '0;
    bus_if.vector_y   = '0;

    // Reset values
    step(1'b0, 1'b0, 16'h0, 4'h0);
    chk("rst_best", {16'd0, bus_if.best_dist}, 32'hFFFF);
    chk("rst_cnt",  {23'd0, bus_if.cand_count}, 32'd0);
    chk("rst_done", {31'd0, bus_if.done}, 32'd0);
    $display("txn reset best=%h cnt=%0d", bus_if.best_dist, bus_if.cand_count);

    // Full window with a single planted minimum
    step(1'b1, 1'b1, 16'h0, 4'h0);
    sweep(0);
    chk("full_cnt", {23'd0, bus_if.cand_count}, 32'd256);
    step(1'b1, 1'b1, 16'h0, 4'h0);
    chk("full_done", {31'd0, bus_if.done}, 32'd1);
    chk("full_best", {16'd0, bus_if.best_dist}, 32'h0010);
    chk("full_mx",   {28'd0, bus_if.motion_x}, 32'h2);
    chk("full_my",   {28'd0, bus_if.motion_y}, 32'h3);
    $display("txn full best=%h mx=%h my=%h", bus_if.best_dist, bus_if.motion_x, bus_if.motion_y);

    // Ready bits while finished are ignored
    set_all(16'h0000);
    repeat (3) step(1'b1, 1'b1, 16'hFFFF, 4'h0);
    chk("done_hold_best", {16'd0, bus_if.best_dist}, 32'h0010);
    chk("done_hold_cnt",  {23'd0, bus_if.cand_count}, 32'd256);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    chk("done_exit", {31'd0, bus_if.done}, 32'd0);
    $display("txn done_hold done=%b", bus_if.done);

    // Tie: earlier candidate wins
    step(1'b1, 1'b1, 16'h0, 4'h0);
    sweep(1);
    step(1'b1, 1'b1, 16'h0, 4'h0);
    chk("tie_mx", {28'd0, bus_if.motion_x}, 32'hB);
    chk("tie_my", {28'd0, bus_if.motion_y}, 32'h9);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    $display("txn tie mx=%h my=%h", bus_if.motion_x, bus_if.motion_y);

    // Simultaneous ready: PE15 deferred one cycle with its captured row
    step(1'b1, 1'b1, 16'h0, 4'h0);
    set_all(16'hFFFF);
    d[0] = 16'h0040; d[15] = 16'h0020;
    step(1'b1, 1'b1, 16'h8001, 4'h1);
    chk("sim_best1", {16'd0, bus_if.best_dist}, 32'h0040);
    step(1'b1, 1'b1, 16'h0000, 4'h5);
    chk("sim_best", {16'd0, bus_if.best_dist}, 32'h0020);
    chk("sim_mx",   {28'd0, bus_if.motion_x}, 32'h8);
    chk("sim_my",   {28'd0, bus_if.motion_y}, 32'h1);
    chk("sim_cnt",  {23'd0, bus_if.cand_count}, 32'd2);
    $display("txn simultaneous best=%h mx=%h my=%h", bus_if.best_dist, bus_if.motion_x, bus_if.motion_y);

    // Abort after 100 candidates, then restart
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b1, 16'h0, 4'h0);
    guard = 0;
    while (m_cnt < 100 && guard < 2000) begin rand_step(1'b1); guard++; end
    chk("abort_reach", 32'(m_cnt), 32'd100);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    chk("abort_done", {31'd0, bus_if.done}, 32'd0);
    step(1'b1, 1'b0, 16'hFFFF, 4'h2);
    chk("abort_idle_cnt", {23'd0, bus_if.cand_count}, 32'd100);
    step(1'b1, 1'b1, 16'h0, 4'h0);
    chk("restart_cnt",  {23'd0, bus_if.cand_count}, 32'd0);
    chk("restart_best", {16'd0, bus_if.best_dist}, 32'hFFFF);
    $display("txn abort/restart cnt=%0d", bus_if.cand_count);

    // Reset in the middle of a search
    repeat (40) rand_step(1'b1);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    chk("midrst_best", {16'd0, bus_if.best_dist}, 32'hFFFF);
    chk("midrst_cnt",  {23'd0, bus_if.cand_count}, 32'd0);
    chk("midrst_done", {31'd0, bus_if.done}, 32'd0);
    step(1'b1, 1'b1, 16'h0, 4'h0);
    repeat (4) step(1'b1, 1'b1, 16'h0, 4'h0);
    chk("midrst_nopend", {23'd0, bus_if.cand_count}, 32'd0);
    $display("txn midsearch_reset cnt=%0d", bus_if.cand_count);

    // Random full search, saturating with queued candidates at the end
    guard = 0;
    while (!m_done && guard < 3000) begin rand_step(1'b1); guard++; end
    chk("rand_done", {31'd0, bus_if.done}, 32'd1);
    chk("rand_cnt",  {23'd0, bus_if.cand_count}, 32'd256);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    $display("txn random best=%h mx=%h my=%h", bus_if.best_dist, bus_if.motion_x, bus_if.motion_y);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/best_match_comparator.md
Name: best_match_comparator

Overview:
- Downstream stage of the motion-estimation control/PE array.
- Consumes per-PE distortion results as the PEs signal ready, and tracks the minimum distortion and its motion vector over a full search window.
- Presents the best match with a done flag to the output/writeback logic.
- Absorbs simultaneous PE-ready bits through a pending mask, so no candidate is lost.

Parameters:
- NUM_PE, 16, number of processing elements (one per horizontal offset)
- DIST_W, 16, distortion width (256 pixels x 8-bit abs-diff sum)
- NUM_CAND, 256, candidates per search (NUM_PE x 16 rows)
- VEC_OFFSET, 7, bias subtracted from PE index / row to form the signed vector

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- comp_start  in  1  search-active level from control; a 0->1 edge starts a search
- pe_ready  in  NUM_PE  bit i = PE i distortion valid this cycle
- pe_dist  in  NUM_PE*DIST_W  flat bus; PE i occupies bits [i*DIST_W +: DIST_W]
- vector_y  in  4  row vector (two's complement) for PEs reporting this cycle
- best_dist  out  DIST_W  minimum distortion so far
- motion_x  out  4  x vector of best match, two's complement
- motion_y  out  4  y vector of best match, two's complement
- cand_count  out  9  candidates compared in current search
- done  out  1  search complete; results stable

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE
  - best_dist=all ones
  - motion_x=0, motion_y=0
  - cand_count=0
  - done=0
  - pending mask=0
- FSM states and transitions:
  - IDLE -> SEARCH on a comp_start rising edge (registered previous value). On entry: best_dist=all ones, cand_count=0, pending=0, done=0.
  - SEARCH -> DONE in the cycle after cand_count reaches NUM_CAND.
  - SEARCH -> IDLE if comp_start falls (abort). Pending is cleared, done stays 0, best_dist/motion keep partial values.
  - DONE: done=1; outputs held. DONE -> IDLE when comp_start=0. DONE returns to IDLE first, so a new search needs a fresh rising edge.
- Candidate selection per cycle in SEARCH:
  - Working set = pending | pe_ready.
  - Lowest set index k is compared this cycle; its bit is cleared.
  - All other set bits go to pending.
- Row capture:
  - Each newly set pe_ready bit i captures vector_y into a per-PE row register ypend[i] in that same cycle.
  - A pending candidate uses its captured row, not the current vector_y.
  - Distortion is sampled from pe_dist at compare time; PEs hold results until re-armed (pending depth ≤ NUM_PE cycles).
- Compare:
  - cand_x = k - VEC_OFFSET, truncated to 4 bits.
  - If pe_dist[k] < best_dist (strict), update best_dist, motion_x=cand_x, motion_y=row. Ties keep the earlier candidate.
  - cand_count increments by 1 per compared candidate.
- Latency: a candidate compared at edge N is reflected in best_dist/motion/cand_count after edge N, visible in cycle N+1.
- Collision case: a pe_ready bit for PE i arriving while pending[i] is already set is a protocol error. The new value overwrites ypend[i] and only one candidate is counted.
- pe_ready is ignored in IDLE and DONE.
- cand_count saturates at NUM_CAND; extra ready bits in the final cycle are dropped.

Decomposition:
- Shared package me_pkg:
  - NUM_PE, DIST_W, NUM_CAND, VEC_OFFSET
  - state enum {IDLE, SEARCH, DONE}
  - typedef dist_t (logic [DIST_W-1:0])
  - typedef vec_t (logic signed [3:0])
- Sub-module: lowest_set_picker, a combinational priority encoder. Inputs: NUM_PE mask. Outputs: index, valid, mask-with-lowest-cleared.
- Comparator/registers and the FSM stay in the top module.

Test Plan:
- Reset during SEARCH (reset_n=0 one cycle) -> next cycle state IDLE, best_dist=FFFF, done=0, cand_count=0, pending=0.
- comp_start 0->1, then one-hot pe_ready walking i=0..15 per row, vector_y -7..8, all dist=0x0100 except PE 9 at row 3 (vector_y=3) dist=0x0010 -> after 256 candidates: done=1, best_dist=0x0010, motion_x=2, motion_y=3.
- Tie: PE 2 row -7 and PE 5 row 0 both dist=0x0005 (global min) -> motion_x=-5 (4'hB), motion_y=-7 (4'h9). The earlier candidate wins.
- Simultaneous: pe_ready=16'h8001 with vector_y=1, dists 0x0040/0x0020, then pe_ready=0 with vector_y=5 -> PE0 compared in cycle 1, PE15 in cycle 2 using y=1. best_dist=0x0020, motion_x=8, motion_y=1, cand_count=2.
- Abort: comp_start falls after 100 candidates -> IDLE next cycle, done=0. A new rising edge restarts with cand_count=0, best_dist=FFFF.
- In DONE, pe_ready=FFFF with dist=0 -> outputs unchanged. Lowering comp_start -> IDLE, done=0.
